// File: rtl/apuf_eval_ctrl_pkg.sv
// Shared definitions for arbiter-PUF evaluation controllers:
// FSM state encoding and a width helper for counters.
package apuf_eval_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } eval_state_t;

    function automatic int clog2_width(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/apuf_eval_ctrl_sync2ff.sv
// Generic two-flop synchroniser for a single asynchronous level,
// cleared by the asynchronous active-low reset.
module sync2ff (
    input  logic clk,
    input  logic rstN,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: fires the core nEval times per
// challenge, majority-votes the synchronised response, reports timeouts.
module apuf_eval_ctrl
    import apuf_eval_ctrl_pkg::*;
#(
    parameter int nStage        = 64,
    parameter int nEval         = 5,
    parameter int settleCycles  = 4,
    parameter int timeoutCycles = 255
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            reqValid,
    output logic                            reqReady,
    input  logic [nStage-1:0]               reqChal,
    output logic [nStage-1:0]               pufChal,
    output logic                            pufTrig,
    input  logic                            pufReady,
    input  logic                            pufResp,
    output logic                            rspValid,
    input  logic                            rspReady,
    output logic                            rspBit,
    output logic [clog2_width(nEval+1)-1:0] rspOnes,
    output logic                            rspErr
);

    localparam int OW   = clog2_width(nEval + 1);
    localparam int TMAX = (timeoutCycles > settleCycles) ?
                          timeoutCycles : settleCycles;
    localparam int TW   = clog2_width(TMAX + 1);

    localparam logic [TW-1:0] SETTLE_LAST = TW'(settleCycles - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(timeoutCycles - 1);
    localparam logic [OW-1:0] N_EVAL      = OW'(nEval);
    localparam logic [OW-1:0] HALF        = OW'(nEval / 2);

    eval_state_t       r_state;
    eval_state_t       w_next;
    logic              r_reqReady;
    logic              r_rspValid;
    logic              r_trig;
    logic [nStage-1:0] r_chal;
    logic [TW-1:0]     r_timer;
    logic [OW-1:0]     r_evalCnt;
    logic [OW-1:0]     r_onesCnt;
    logic              r_bit;
    logic              r_err;

    logic w_readyS;
    logic w_respS;
    logic w_accept;
    logic w_tmo;
    logic w_abort;
    logic w_enterDone;
    logic w_count;

    sync2ff u_sync_ready (
        .clk  (clk),
        .rstN (rstN),
        .i_d  (pufReady),
        .o_q  (w_readyS)
    );

    sync2ff u_sync_resp (
        .clk  (clk),
        .rstN (rstN),
        .i_d  (pufResp),
        .o_q  (w_respS)
    );

    assign w_accept = (r_state == ST_IDLE) && r_reqReady && reqValid;
    assign w_tmo    = (r_timer == TO_LAST);
    assign w_count  = (r_state == ST_SETUP) || (r_state == ST_FIRE) ||
                      (r_state == ST_DRAIN);

    // Timeout wins only while the core has not made the awaited transition.
    assign w_abort = w_tmo &&
                     (((r_state == ST_FIRE) && !w_readyS) ||
                      ((r_state == ST_DRAIN) && w_readyS));

    assign w_enterDone = (w_next == ST_DONE) && (r_state != ST_DONE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (r_timer == SETTLE_LAST) w_next = ST_FIRE;
            end
            ST_FIRE: begin
                if (w_readyS)   w_next = ST_SAMPLE;
                else if (w_tmo) w_next = ST_DONE;
            end
            ST_SAMPLE: begin
                w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!w_readyS)
                    w_next = (r_evalCnt < N_EVAL) ? ST_SETUP : ST_DONE;
                else if (w_tmo)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                if (rspReady) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= ST_IDLE;
            r_reqReady <= 1'b0;
            r_rspValid <= 1'b0;
            r_trig     <= 1'b0;
            r_chal     <= '0;
            r_timer    <= '0;
            r_evalCnt  <= '0;
            r_onesCnt  <= '0;
            r_bit      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_reqReady <= (w_next == ST_IDLE);
            r_rspValid <= (w_next == ST_DONE);
            r_trig     <= (w_next == ST_FIRE) || (w_next == ST_SAMPLE);

            if ((w_next != r_state) || !w_count)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);

            if (w_accept) begin
                r_chal    <= reqChal;
                r_evalCnt <= '0;
                r_onesCnt <= '0;
                r_bit     <= 1'b0;
                r_err     <= 1'b0;
            end

            if (r_state == ST_SAMPLE) begin
                r_evalCnt <= r_evalCnt + OW'(1);
                r_onesCnt <= r_onesCnt + OW'(w_respS);
            end

            if (w_abort)
                r_err <= 1'b1;

            if (w_enterDone)
                r_bit <= !w_abort && (r_onesCnt > HALF);
        end
    end

    assign reqReady = r_reqReady;
    assign pufChal  = r_chal;
    assign pufTrig  = r_trig;
    assign rspValid = r_rspValid;
    assign rspBit   = r_bit;
    assign rspOnes  = r_onesCnt;
    assign rspErr   = r_err;

endmodule

// File: doc/apuf_eval_ctrl.md
# apuf_eval_ctrl

Evaluation controller that sits directly upstream and downstream of the arbiter PUF core. It accepts a challenge over a valid/ready request interface, drives the core's challenge and trigger inputs, and synchronises the asynchronous ready and response outputs into the clk domain. It repeats the evaluation nEval times, majority-votes the response bits, and returns the result over a valid/ready response interface, with a timeout error if the core never completes.

## Interface
- nStage, 64: challenge width; matches the PUF core's stage count.
- nEval, 5: evaluations per challenge; odd, ≥1.
- settleCycles, 4: cycles the trigger is held low with the challenge applied before each fire; ≥1.
- timeoutCycles, 255: maximum cycles spent waiting for pufReady to rise (FIRE) or fall (DRAIN); ≥4.
- clk  in  1  system clock; all state changes on its rising edge.
- rstN  in  1  asynchronous, active-low reset.
- reqValid  in  1  challenge request valid.
- reqReady  out  1  controller can accept a request.
- reqChal  in  nStage  challenge to evaluate.
- pufChal  out  nStage  registered challenge driven to the core's c input.
- pufTrig  out  1  registered trigger driven to the core's tigSignal input.
- pufReady  in  1  core's respReady; asynchronous.
- pufResp  in  1  core's respBit; asynchronous.
- rspValid  out  1  result valid; held until accepted.
- rspReady  in  1  consumer accepts the result.
- rspBit  out  1  majority-voted response.
- rspOnes  out  clog2(nEval+1)  count of evaluations that returned 1.
- rspErr  out  1  evaluation aborted by timeout.

## Operation
- Reset (async assert, sync release) values: state IDLE; pufTrig 0; pufChal 0; reqReady 0 during reset and 1 on the first cycle after release; rspValid, rspBit, rspOnes, rspErr 0; synchronisers cleared.
- Synchronisers: two-flop chains on pufReady (readyS) and pufResp (respS). No other logic uses the raw inputs.
- States:
  - IDLE: reqReady=1. reqValid&reqReady latches reqChal into pufChal, clears evalCnt/onesCnt/timer, and moves to SETUP.
  - SETUP: pufTrig=0 for settleCycles cycles, then FIRE.
  - FIRE: pufTrig=1. Moves to SAMPLE on the first cycle readyS=1. Moves to DONE with rspErr=1 after timeoutCycles cycles without readyS.
  - SAMPLE: one cycle. onesCnt += respS, evalCnt += 1. Moves to DRAIN.
  - DRAIN: pufTrig=0. Waits for readyS=0, with the same timeout as FIRE (error goes to DONE). When readyS=0: SETUP if evalCnt<nEval, otherwise DONE.
  - DONE: rspValid=1; rspBit = (onesCnt > nEval/2); rspOnes=onesCnt. rspValid&rspReady moves to IDLE.
- Outputs are stable for the whole time rspValid is high.
- Timeout abort: pufTrig is 0 in DONE, rspBit=0, and rspOnes holds the partial count.
- pufChal changes only on request accept, so it never changes while pufTrig=1.
- reqValid is ignored outside IDLE. Back-to-back requests: the next accept can occur on the cycle after the response handshake.
- Reset asserted mid-evaluation: pufTrig drops to 0 asynchronously and any pending result is discarded.
- onesCnt is saturation-free by construction, since it is ≤ nEval and fits in clog2(nEval+1) bits.

## Timing
- With an ideal core (pufReady follows pufTrig combinationally), each evaluation costs settleCycles + 7 cycles:
  - SETUP: S cycles.
  - FIRE: 3 cycles (2-flop latency plus detect).
  - SAMPLE: 1 cycle.
  - DRAIN: 3 cycles.
- From the accept edge to the first cycle of rspValid: nEval·(settleCycles+7)+1 cycles. This is 56 cycles at the defaults.
- respS is sampled one cycle after readyS rises. The core's latch has settled ≥3 clk periods before the sample is taken.
- Timeout counts from FIRE or DRAIN entry. rspValid rises the cycle after the timer reaches timeoutCycles.

## Structure
- Shared package: the state enum (IDLE, SETUP, FIRE, SAMPLE, DRAIN, DONE) and the clog2 width function. These are reused by future multi-PUF (XOR) controllers.
- One sub-module: sync2ff, a generic 2-flop synchroniser with async active-low reset. It is instantiated twice here and is reused elsewhere.
- The PUF core itself is not instantiated here. The top level connects it to this block.

## Test plan
- Ideal-core model that always returns 1, defaults, challenge 64'hA5A5_0000_FFFF_1234 -> pufChal equals that challenge; rspValid after 56 cycles; rspBit=1, rspOnes=5, rspErr=0.
- Core model returning sequence 1,0,1,0,0 -> rspBit=0, rspOnes=2; pufTrig shows exactly 5 high pulses, each preceded by ≥4 low cycles.
- Core that never asserts respReady, timeoutCycles=255 -> rspErr=1, rspBit=0, rspOnes=0; pufTrig back to 0; rspValid 4+255+1 cycles after accept.
- rspReady held low for 20 cycles in DONE, reqValid high throughout -> outputs stable and reqReady=0 until the handshake; the next request is accepted the following cycle.
- rstN asserted during the third FIRE, then released -> pufTrig=0 immediately; all outputs at reset values; a fresh request completes normally.
- Randomised 1–20 cycle core delay with a fixed per-challenge bit, 100 challenges -> every rspBit matches the model; no trigger glitch while pufChal changes.
